// File: rtl/instruction_sender_if.sv
// Command/response bundle between a host and instruction_sender: one frame
// request in, busy/done status and the assembled response word out.
interface instruction_sender_if;
  logic        start_i;
  logic [7:0]  instruction_i;
  logic [23:0] address_i;
  logic [31:0] value_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (
    output start_i, instruction_i, address_i, value_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, instruction_i, address_i, value_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/instruction_sender.sv
// SPI mode-0 frame sender: shifts instruction/address/value out MSB-first and,
// with INSTRUCTION_SENDER_RESPONSE_EN defined, clocks RESP_BYTES of reply back in.
module instruction_sender #(
  parameter int CLK_DIV    = 4,
  parameter int RESP_BYTES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  instruction_sender_if.slave  cmd,
  output logic                 spi_clock_o,
  output logic                 spi_cs_o,
  output logic                 spi_pico_o,
  input  logic                 spi_poci_i
);

`ifdef INSTRUCTION_SENDER_RESPONSE_EN
  localparam int N = 64 + 8 * RESP_BYTES;
`else
  localparam int N = 64;
  localparam int unused_resp_bytes = RESP_BYTES;
`endif
  localparam int BCNT_W = $clog2(N + 1);
  localparam logic [7:0]        HALF_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT    = BCNT_W'(N - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_CS_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]        r_state;
  logic [7:0]        r_hcnt;
  logic [BCNT_W-1:0] r_bcnt;
  logic              r_busy;
  logic              r_done;
  logic              r_cs;
  logic              r_sclk;
  logic              r_pico;
  logic [N-1:0]      r_sr;

  logic [N-1:0] w_frame;
  logic         w_accept;
  logic         w_tick;
  logic         w_rise;
  logic         w_fall;
  logic         w_last;

  // Command sits in the top 64 bits; response slots below it transmit zero.
  assign w_frame  = N'({cmd.instruction_i, cmd.address_i, cmd.value_i}) << (N - 64);
  assign w_accept = (r_state == S_IDLE) && cmd.start_i;
  assign w_tick   = (r_hcnt == 8'd0);
  assign w_rise   = (r_state == S_SHIFT) && w_tick && !r_sclk;
  assign w_fall   = (r_state == S_SHIFT) && w_tick && r_sclk;
  assign w_last   = (r_bcnt == LAST_BIT);

  // Stage p0: control FSM, SPI pins and counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_pico  <= 1'b0;
      r_hcnt  <= 8'd0;
      r_bcnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd.start_i) begin
            r_state <= S_CS_SETUP;
            r_busy  <= 1'b1;
            r_cs    <= 1'b0;
            r_sclk  <= 1'b0;
            r_pico  <= w_frame[N-1];
            r_hcnt  <= HALF_RELOAD;
            r_bcnt  <= '0;
          end
        end
        S_CS_SETUP: begin
          if (w_tick) begin
            r_state <= S_SHIFT;
            r_hcnt  <= HALF_RELOAD;
          end else begin
            r_hcnt <= r_hcnt - 8'd1;
          end
        end
        S_SHIFT: begin
          if (!w_tick) begin
            r_hcnt <= r_hcnt - 8'd1;
          end else begin
            r_hcnt <= HALF_RELOAD;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // PICO only ever moves together with the falling SCLK edge
              r_sclk <= 1'b0;
              if (w_last) begin
                r_state <= S_CS_HOLD;
                r_pico  <= 1'b0;
              end else begin
                r_bcnt <= r_bcnt + BCNT_W'(1);
                r_pico <= r_sr[N-2];
              end
            end
          end
        end
        S_CS_HOLD: begin
          if (w_tick) begin
            r_state <= S_DONE;
            r_cs    <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_hcnt <= r_hcnt - 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: transmit shift register (data path, no reset)
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_sr <= w_frame;
    end else if (w_fall) begin
      r_sr <= r_sr << 1;
    end
  end

`ifdef INSTRUCTION_SENDER_RESPONSE_EN
  localparam logic [BCNT_W-1:0] FIRST_RESP = BCNT_W'(64);

  logic [31:0] r_rx;
  logic [31:0] r_result;

  // Stage p0: response capture, only bits past the 64-bit command
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_rx <= 32'd0;
    end else if (w_rise && (r_bcnt >= FIRST_RESP)) begin
      r_rx <= {r_rx[30:0], spi_poci_i};
    end
  end

  // Stage p1: result register, updated only on the DONE transition
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_result <= 32'd0;
    end else if ((r_state == S_CS_HOLD) && w_tick) begin
      r_result <= r_rx;
    end
  end

  assign cmd.result_o = r_result;
`else
  logic w_unused_poci;
  assign w_unused_poci = spi_poci_i;
  assign cmd.result_o  = 32'd0;
`endif

  assign cmd.busy_o  = r_busy;
  assign cmd.done_o  = r_done;
  assign spi_clock_o = r_sclk;
  assign spi_cs_o    = r_cs;
  assign spi_pico_o  = r_pico;

endmodule

// File: tb/tb_instruction_sender.sv
// Directed bench for instruction_sender: one CLK_DIV=4 instance with a reply
// model and one CLK_DIV=1 instance for back-to-back framing.
`define CHK(TAG, OBS, EXP) begin checks++; assert (96'(OBS) === 96'(EXP)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", TAG, 96'(OBS), 96'(EXP)); end end

module tb_instruction_sender;

`ifdef INSTRUCTION_SENDER_RESPONSE_EN
  localparam int          TB_N     = 96;
  localparam int          EXP_DONE = 777;
  localparam logic [31:0] EXP_RES  = 32'h12345678;
`else
  localparam int          TB_N     = 64;
  localparam int          EXP_DONE = 521;
  localparam logic [31:0] EXP_RES  = 32'h0;
`endif
  localparam int          EXP_DONE1 = 3 + 2 * TB_N;
  localparam logic [95:0] EXP_BITS_A = {64'h01000002DEADBEEF, 32'h0} >> (96 - TB_N);
  localparam logic [95:0] EXP_BITS_D = {64'hA55A0F3C80000001, 32'h0} >> (96 - TB_N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sclk0, cs0, pico0, poci0;
  logic sclk1, cs1, pico1, poci1;

  instruction_sender_if bus0 ();
  instruction_sender_if bus1 ();

  instruction_sender #(.CLK_DIV(4), .RESP_BYTES(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .cmd(bus0),
    .spi_clock_o(sclk0), .spi_cs_o(cs0), .spi_pico_o(pico0), .spi_poci_i(poci0)
  );

  instruction_sender #(.CLK_DIV(1), .RESP_BYTES(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .cmd(bus1),
    .spi_clock_o(sclk1), .spi_cs_o(cs1), .spi_pico_o(pico1), .spi_poci_i(poci1)
  );

  // Peripheral: bit index = SCLK rises seen so far; reply occupies bits 64..95
  int          rcnt = 0;
  logic [31:0] resp_word = 32'h12345678;
  always @(negedge cs0 or posedge sclk0) begin
    if (sclk0) rcnt <= rcnt + 1;
    else       rcnt <= 0;
  end
  assign poci0 = (rcnt >= 64 && rcnt < 96) ? resp_word[5'(95 - rcnt)] : 1'b0;
  assign poci1 = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic run_frame(input logic [7:0] ins, input logic [23:0] adr,
                           input logic [31:0] val, input int inject_at, input int abort_at,
                           output int done_cyc, output logic [95:0] bits, output int nb,
                           output int viol, output logic first_cs, output logic first_busy,
                           output logic aborted);
    logic prev_cs, prev_sclk, prev_pico;
    done_cyc = -1; bits = '0; nb = 0; viol = 0; aborted = 1'b0;
    first_cs = 1'bx; first_busy = 1'bx;
    bus0.instruction_i = ins; bus0.address_i = adr; bus0.value_i = val;
    bus0.start_i = 1'b1;
    prev_cs = cs0; prev_sclk = sclk0; prev_pico = pico0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus0.start_i = 1'b0;
        first_cs = cs0; first_busy = bus0.busy_o;
      end
      if (!cs0 && !prev_cs && (pico0 !== prev_pico) && !(prev_sclk && !sclk0)) viol++;
      if (!cs0 && !prev_sclk && sclk0) begin
        bits = {bits[94:0], pico0};
        nb++;
      end
      prev_cs = cs0; prev_sclk = sclk0; prev_pico = pico0;
      if (bus0.done_o) begin
        done_cyc = cyc;
        return;
      end
      if (cyc == inject_at) begin
        bus0.start_i = 1'b1;
        bus0.instruction_i = ~ins; bus0.address_i = ~adr; bus0.value_i = ~val;
      end
      if (cyc == inject_at + 1) bus0.start_i = 1'b0;
      if (cyc == abort_at) begin
        rst = 1'b1;
        bus0.start_i = 1'b1;
        @(negedge clk);
        aborted = 1'b1;
        return;
      end
    end
    checks++;
    if (done_cyc == -1) begin
      errors++;
      $error("FAIL wait_expired: no done_o within 3000 cycles");
    end
  endtask

  initial begin
    int          dc, nb, viol, ndone, cyc, nd, gap, d1, d2, nb1, viol1;
    logic [95:0] bits, bits1;
    logic        fcs, fbusy, ab, cs_ok;
    logic        pcs, psclk, ppico;

    rst = 1'b1;
    bus0.start_i = 1'b0; bus0.instruction_i = '0; bus0.address_i = '0; bus0.value_i = '0;
    bus1.start_i = 1'b0; bus1.instruction_i = '0; bus1.address_i = '0; bus1.value_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cs0 !== 1'b1 || sclk0 !== 1'b0 || pico0 !== 1'b0 || bus0.busy_o !== 1'b0 ||
        bus0.done_o !== 1'b0 || bus0.result_o !== 32'h0) begin
      errors++;
      $error("FAIL reset_state cs=%b sclk=%b pico=%b busy=%b done=%b result=%0h",
             cs0, sclk0, pico0, bus0.busy_o, bus0.done_o, bus0.result_o);
    end
    `CHK("rst_cs", cs0, 1'b1)
    `CHK("rst_sclk", sclk0, 1'b0)
    `CHK("rst_pico", pico0, 1'b0)
    `CHK("rst_busy", bus0.busy_o, 1'b0)
    `CHK("rst_done", bus0.done_o, 1'b0)
    `CHK("rst_result", bus0.result_o, 32'h0)
    rst = 1'b0;
    @(negedge clk);

    // Nominal frame
    run_frame(8'h01, 24'h000002, 32'hDEADBEEF, 0, 0, dc, bits, nb, viol, fcs, fbusy, ab);
    `CHK("a_first_cs", fcs, 1'b0)
    `CHK("a_first_busy", fbusy, 1'b1)
    `CHK("a_done_cycle", dc, EXP_DONE)
    `CHK("a_nbits", nb, TB_N)
    `CHK("a_pico_bits", bits, EXP_BITS_A)
    `CHK("a_pico_edges", viol, 0)
    `CHK("a_result", bus0.result_o, EXP_RES)
    `CHK("a_cs_at_done", cs0, 1'b1)
    `CHK("a_busy_at_done", bus0.busy_o, 1'b1)
    @(negedge clk);
    `CHK("a_done_pulse", bus0.done_o, 1'b0)
    `CHK("a_busy_after", bus0.busy_o, 1'b0)
    `CHK("a_result_hold", bus0.result_o, EXP_RES)

    // Start and input changes while busy are ignored
    repeat (2) @(negedge clk);
    run_frame(8'h01, 24'h000002, 32'hDEADBEEF, 100, 0, dc, bits, nb, viol, fcs, fbusy, ab);
    `CHK("b_done_cycle", dc, EXP_DONE)
    `CHK("b_pico_bits", bits, EXP_BITS_A)
    ndone = 0; cs_ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus0.done_o) ndone++;
      if (!cs0) cs_ok = 1'b0;
    end
    `CHK("b_extra_done", ndone, 0)
    `CHK("b_no_refire", cs_ok, 1'b1)

    // Distinct pattern
    run_frame(8'hA5, 24'h5A0F3C, 32'h80000001, 0, 0, dc, bits, nb, viol, fcs, fbusy, ab);
    `CHK("d_done_cycle", dc, EXP_DONE)
    `CHK("d_pico_bits", bits, EXP_BITS_D)
    `CHK("d_pico_edges", viol, 0)
    `CHK("d_result", bus0.result_o, EXP_RES)
    repeat (2) @(negedge clk);

    // Reset mid-frame, with start held during reset
    run_frame(8'h01, 24'h000002, 32'hDEADBEEF, 0, 300, dc, bits, nb, viol, fcs, fbusy, ab);
    `CHK("c_aborted", ab, 1'b1)
    `CHK("c_cs", cs0, 1'b1)
    `CHK("c_sclk", sclk0, 1'b0)
    `CHK("c_busy", bus0.busy_o, 1'b0)
    `CHK("c_done", bus0.done_o, 1'b0)
    `CHK("c_result", bus0.result_o, 32'h0)
    rst = 1'b0;
    bus0.start_i = 1'b0;
    ndone = 0; cs_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus0.done_o) ndone++;
      if (!cs0) cs_ok = 1'b0;
    end
    `CHK("c_no_done", ndone, 0)
    `CHK("c_cs_idle", cs_ok, 1'b1)

    // CLK_DIV=1, start held high: two back-to-back frames
    bus1.instruction_i = 8'h01; bus1.address_i = 24'h000002; bus1.value_i = 32'hDEADBEEF;
    bus1.start_i = 1'b1;
    cyc = 0; nd = 0; gap = 0; d1 = -1; d2 = -1; nb1 = 0; viol1 = 0; bits1 = '0;
    pcs = cs1; psclk = sclk1; ppico = pico1;
    for (int k = 0; k < 1000 && nd < 2; k++) begin
      @(negedge clk);
      cyc++;
      if (!cs1 && !pcs && (pico1 !== ppico) && !(psclk && !sclk1)) viol1++;
      if (nd == 0 && !cs1 && !psclk && sclk1) begin
        bits1 = {bits1[94:0], pico1};
        nb1++;
      end
      pcs = cs1; psclk = sclk1; ppico = pico1;
      if (bus1.done_o) begin
        nd++;
        if (nd == 1) d1 = cyc;
        else d2 = cyc;
      end
      if (nd == 1 && cs1) gap++;
    end
    bus1.start_i = 1'b0;
    `CHK("e_frames", nd, 2)
    `CHK("e_done1_cycle", d1, EXP_DONE1)
    `CHK("e_frame_spacing", d2 - d1, 4 + 2 * TB_N)
    `CHK("e_cs_gap", gap, 2)
    `CHK("e_pico_edges", viol1, 0)
    `CHK("e_nbits", nb1, TB_N)
    `CHK("e_pico_bits", bits1, EXP_BITS_A)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
